irq_claim_unit: RTL and testbench
=================================

Name: irq_claim_unit

Overview:
- Core-side counterpart to the peripheral interrupt aggregator.
- Captures the 13 peripheral status lines into a sticky pending register and applies a per-source enable mask.
- Raises irq to the core, then runs a claim/complete handshake over a small register port so software can identify, service and retire one source at a time, lowest index first.

Parameters:
NSRC, 13, number of interrupt sources (1..31)
ID_W, 5, claim ID width; ID 5'h1F means "no source"

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
status  in  NSRC  raw peripheral status lines, synchronous to clk
wen  in  1  register write strobe, single cycle
ren  in  1  register read strobe, single cycle
addr  in  2  register select
wdata  in  32  write data
rdata  out  32  read data, registered
rvalid  out  1  read data valid
irq  out  1  interrupt request to core
active_id  out  ID_W  ID of the source currently in service; 5'h1F when none

Behaviour:
- Reset values (n_rst=0, asynchronous):
  - pending=0, status_q=0, state=IDLE
  - enable=NSRC'h006D (bits 0,2,3,5,6)
  - irq=0, rdata=0, rvalid=0, active_id=5'h1F
- Edge capture: pending[i] sets on the rising edge of status (status[i] & ~status_q[i]); status_q registers status every cycle.
- Register map, 32-bit, unused bits read 0:
  - addr 0 PENDING: read returns pending. Write-1-to-clear (pending &= ~wdata).
  - addr 1 ENABLE: read/write.
  - addr 2 CLAIM: read = claim; write = complete.
  - addr 3 ACTIVE: read-only, returns active_id.
- Define req = pending & enable. sel = lowest index i with req[i]=1, else 5'h1F.
- Read timing: rdata and rvalid are valid in the cycle after ren; rvalid is high for exactly one cycle.
- Strobe collision: if wen and ren are high in the same cycle, the write executes, the read is dropped and rvalid stays 0.
- Set/clear collision on one bit in the same cycle: set wins.
- FSM:
  - IDLE: irq=0. If req!=0 -> ARMED.
  - ARMED: irq=1.
    - CLAIM read: rdata=sel, pending[sel] clears, active_id<=sel -> SERVICE.
    - If req becomes 0 (W1C or enable cleared) before a claim -> IDLE. irq drops the next cycle.
  - SERVICE: irq=0; new edges still accumulate in pending.
    - CLAIM write with wdata[ID_W-1:0]==active_id: active_id<=5'h1F -> IDLE.
    - Mismatched ID: write ignored, state held.
    - CLAIM read returns 5'h1F and has no side effects.
- CLAIM read in IDLE returns 5'h1F with no side effects.
- irq is a registered output: it asserts 1 cycle after entering ARMED, 2 cycles after the status edge.
- Back-to-back operation: completing while req!=0 goes IDLE -> ARMED, and irq reasserts 2 cycles after the complete write.
- Reset mid-service: all state returns to reset values immediately; any pending work is lost.
- Only one source is in service at a time; no nesting or preemption.

Optional Feature:
IRQ_LEVEL_EN
- Defined: pending is not sticky and pending = status_q every cycle.
  - PENDING W1C writes have no effect.
  - Claim does not clear the bit; the source must drop its status line before completing, otherwise the same source is re-raised.
- Undefined: edge-captured sticky pending with W1C, as described above.

Test Plan:
- Reset, then read ENABLE -> rdata=0x0000006D, irq=0, ACTIVE=0x1F.
- status[2] 0->1 at cycle t -> irq=1 at t+2. CLAIM read -> rdata=2, irq=0, PENDING=0. Write CLAIM=2 -> ACTIVE=0x1F.
- status[5] and status[0] rise together -> first CLAIM read returns 0. Complete 0 -> irq reasserts 2 cycles later. Second CLAIM read returns 5.
- status[1] rises (enable bit 1 clear) -> PENDING=0x2, irq stays 0. Write ENABLE=0x2 -> irq=1. Write PENDING=0x2 -> irq=0 next cycle.
- In SERVICE with active_id=3, write CLAIM=4 -> state held, ACTIVE=3. Assert n_rst=0 mid-service -> irq=0, ACTIVE=0x1F, PENDING=0 immediately.
- status[6] rises in the same cycle as a PENDING W1C of 0x40 -> PENDING[6]=1. Same-cycle wen+ren -> rvalid=0.

Source files
------------

// File: rtl/irq_claim_unit.sv
// Core-side interrupt claim unit: captures peripheral status into pending, masks it,
// raises irq and runs a lowest-index-first claim/complete handshake. Define IRQ_LEVEL_EN for level-sensitive pending.
module irq_claim_unit #(
   parameter int unsigned NSRC = 13,
   parameter int unsigned ID_W = 5
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [NSRC-1:0]  status,
   input  logic             wen,
   input  logic             ren,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rvalid,
   output logic             irq,
   output logic [ID_W-1:0]  active_id
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   localparam logic [1:0] A_PENDING = 2'd0;
   localparam logic [1:0] A_ENABLE  = 2'd1;
   localparam logic [1:0] A_CLAIM   = 2'd2;
   localparam logic [1:0] A_ACTIVE  = 2'd3;

   localparam logic [ID_W-1:0] NO_ID  = '1;
   localparam logic [NSRC-1:0] EN_RST = NSRC'(32'h0000_006D);

   logic [1:0]      state;
   logic [1:0]      state_n;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] pending_n;
   logic [NSRC-1:0] status_q;
   logic [NSRC-1:0] enable;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] sel_oh;
   logic [ID_W-1:0] sel;
   logic            any_req;
   logic            rd;
   logic            wr_pend;
   logic            wr_en;
   logic            claim_take;
   logic            cmpl;
   logic [31:0]     rd_val;
   logic            unused_bits;

   assign req     = pending & enable;
   assign any_req = |req;

   // Lowest-index requesting source, both as an ID and as a one-hot clear mask
   always_comb begin
      sel    = NO_ID;
      sel_oh = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel       = ID_W'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
   end

   // A simultaneous write wins over a read; the read is dropped entirely
   assign rd         = ren & ~wen;
   assign wr_pend    = wen && (addr == A_PENDING);
   assign wr_en      = wen && (addr == A_ENABLE);
   assign claim_take = rd && (addr == A_CLAIM) && (state == ARMED) && any_req;
   assign cmpl       = wen && (addr == A_CLAIM) && (state == SERVICE) &&
                       (wdata[ID_W-1:0] == active_id);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (any_req) state_n = ARMED;
         ARMED: begin
            if (claim_take)    state_n = SERVICE;
            else if (!any_req) state_n = IDLE;
         end
         SERVICE: if (cmpl) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

`ifdef IRQ_LEVEL_EN
   assign pending_n   = status;
   assign unused_bits = ^{wdata[31:NSRC], status_q, wr_pend, sel_oh};
`else
   // New edges are OR-ed in after clearing so a same-cycle set beats a clear
   assign pending_n = (pending & ~((wr_pend ? wdata[NSRC-1:0] : '0) |
                                   (claim_take ? sel_oh : '0)))
                      | (status & ~status_q);
   assign unused_bits = ^wdata[31:NSRC];
`endif

   always_comb begin
      rd_val = '0;
      case (addr)
         A_PENDING: rd_val = 32'(pending);
         A_ENABLE:  rd_val = 32'(enable);
         A_CLAIM:   rd_val = claim_take ? 32'(sel) : 32'(NO_ID);
         A_ACTIVE:  rd_val = 32'(active_id);
         default:   rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pending   <= '0;
         status_q  <= '0;
         enable    <= EN_RST;
         irq       <= 1'b0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         active_id <= NO_ID;
      end else begin
         status_q <= status;
         pending  <= pending_n;
         if (wr_en) enable <= wdata[NSRC-1:0];
         rvalid <= rd;
         if (rd) rdata <= rd_val;
         // irq only while ARMED is held, so it drops together with the claim data
         irq <= (state == ARMED) && (state_n == ARMED);
         if (claim_take)  active_id <= sel;
         else if (cmpl)   active_id <= NO_ID;
      end
   end

endmodule

// File: tb/tb_irq_claim_unit.sv
// Testbench for irq_claim_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_irq_claim_unit;

   localparam int unsigned NSRC = 13;
   localparam int unsigned ID_W = 5;

   localparam logic [1:0] M_IDLE    = 2'd0;
   localparam logic [1:0] M_ARMED   = 2'd1;
   localparam logic [1:0] M_SERVICE = 2'd2;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic [NSRC-1:0]  status = '0;
   logic             wen = 1'b0;
   logic             ren = 1'b0;
   logic [1:0]       addr = 2'd0;
   logic [31:0]      wdata = '0;
   logic [31:0]      rdata;
   logic             rvalid;
   logic             irq;
   logic [ID_W-1:0]  active_id;

   int checks = 0;
   int failures = 0;

   irq_claim_unit #(.NSRC(NSRC), .ID_W(ID_W)) dut (
      .clk(clk), .n_rst(n_rst), .status(status), .wen(wen), .ren(ren),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
      .irq(irq), .active_id(active_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0] pend;
      logic [12:0] stq;
      logic [12:0] en;
      logic [1:0]  mode;
      logic [4:0]  act;
      logic        irq;
      logic        rvalid;
      logic [31:0] rdata;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t model_reset();
      mdl_t r;
      r.pend = '0; r.stq = '0; r.en = 13'h006D; r.mode = M_IDLE;
      r.act = 5'h1F; r.irq = 1'b0; r.rvalid = 1'b0; r.rdata = '0;
      return r;
   endfunction

   // One clock of the software-visible behaviour: serve the lowest requesting source
   function automatic mdl_t model_next(mdl_t c, logic [12:0] st, logic w, logic r,
                                       logic [1:0] a, logic [31:0] d);
      mdl_t n;
      logic [12:0] req;
      int lo;
      logic take;
      logic done;
      logic rd;
      n = c;
      req = c.pend & c.en;
      lo = 31;
      for (int i = 12; i >= 0; i--) if (req[i]) lo = i;
      rd = r && !w;
      take = (c.mode == M_ARMED) && rd && (a == 2'd2) && (req != 0);
      done = (c.mode == M_SERVICE) && w && (a == 2'd2) && (d[4:0] == c.act);
      if (c.mode == M_IDLE && req != 0)        n.mode = M_ARMED;
      else if (c.mode == M_ARMED && take)      n.mode = M_SERVICE;
      else if (c.mode == M_ARMED && req == 0)  n.mode = M_IDLE;
      else if (done)                           n.mode = M_IDLE;
      n.rvalid = rd;
      if (rd) begin
         if (a == 2'd0)      n.rdata = {19'd0, c.pend};
         else if (a == 2'd1) n.rdata = {19'd0, c.en};
         else if (a == 2'd2) n.rdata = take ? 32'(lo) : 32'h1F;
         else                n.rdata = {27'd0, c.act};
      end
      if (w && a == 2'd0) n.pend = n.pend & ~d[12:0];
      if (take) n.pend[lo] = 1'b0;
      n.pend = n.pend | (st & ~c.stq);
      if (w && a == 2'd1) n.en = d[12:0];
      if (take)      n.act = 5'(lo);
      else if (done) n.act = 5'h1F;
      n.irq = (c.mode == M_ARMED) && (n.mode == M_ARMED);
      n.stq = st;
      return n;
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) m <= model_reset();
      else        m <= model_next(m, status, wen, ren, addr, wdata);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("irq", 32'(irq), 32'(m.irq));
      chk("active_id", 32'(active_id), 32'(m.act));
      chk("rvalid", 32'(rvalid), 32'(m.rvalid));
      if (m.rvalid) chk("rdata", rdata, m.rdata);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a; ren = 1'b1;
      tick();
      ren = 1'b0;
      d = rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; wen = 1'b1;
      tick();
      wen = 1'b0;
   endtask

   logic [31:0] v;
   int r;

   initial begin
      tick(3);
      n_rst = 1'b1;
      tick();

      // Reset state
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_active", 32'(active_id), 32'h1F);
      rd(2'd1, v); chk("rst_enable", v, 32'h6D);
      rd(2'd3, v); chk("rst_active_reg", v, 32'h1F);

      // Single source: irq two edges after capture, claim, complete
      status = 13'h0004;
      tick(); chk("irq_lat_t0", 32'(irq), 32'h0);
      tick(); chk("irq_lat_t1", 32'(irq), 32'h0);
      tick(); chk("irq_lat_t2", 32'(irq), 32'h1);
      rd(2'd2, v); chk("claim_2", v, 32'h2);
      chk("irq_after_claim", 32'(irq), 32'h0);
      rd(2'd0, v); chk("pend_after_claim", v, 32'h0);
      wr(2'd2, 32'h2);
      rd(2'd3, v); chk("active_after_cmpl", v, 32'h1F);
      status = '0;

      // Two sources, lowest first, back-to-back rearm
      status = 13'h0021;
      tick(3);
      rd(2'd2, v); chk("claim_first_0", v, 32'h0);
      wr(2'd2, 32'h0);
      chk("rearm_t0", 32'(irq), 32'h0);
      tick(); chk("rearm_t1", 32'(irq), 32'h0);
      tick(); chk("rearm_t2", 32'(irq), 32'h1);
      rd(2'd2, v); chk("claim_second_5", v, 32'h5);
      wr(2'd2, 32'h5);
      status = '0;

      // Masked source, enable it, then retire by W1C
      status = 13'h0002;
      tick(3); chk("masked_no_irq", 32'(irq), 32'h0);
      rd(2'd0, v); chk("masked_pend", v, 32'h2);
      wr(2'd1, 32'h2);
      tick(); tick(); chk("enabled_irq", 32'(irq), 32'h1);
      wr(2'd0, 32'h2);
      tick(); chk("w1c_irq_drop", 32'(irq), 32'h0);
      wr(2'd1, 32'h6D);
      status = '0;

      // Wrong complete ID is ignored; reset mid-service
      status = 13'h0008;
      tick(3);
      rd(2'd2, v); chk("claim_3", v, 32'h3);
      wr(2'd2, 32'h4);
      rd(2'd3, v); chk("bad_cmpl_active", v, 32'h3);
      chk("bad_cmpl_irq", 32'(irq), 32'h0);
      status = '0;
      n_rst = 1'b0;
      #1;
      chk("midrst_irq", 32'(irq), 32'h0);
      chk("midrst_active", 32'(active_id), 32'h1F);
      tick();
      n_rst = 1'b1;
      rd(2'd0, v); chk("midrst_pend", v, 32'h0);

      // Set beats same-cycle clear; write beats same-cycle read
      status = 13'h0040;
      addr = 2'd0; wdata = 32'h40; wen = 1'b1;
      tick();
      wen = 1'b0;
      rd(2'd0, v); chk("set_wins", v, 32'h40);
      rd(2'd2, v); chk("claim_6", v, 32'h6);
      wr(2'd2, 32'h6);
      addr = 2'd1; wdata = 32'h6D; wen = 1'b1; ren = 1'b1;
      tick();
      wen = 1'b0; ren = 1'b0;
      chk("collide_rvalid", 32'(rvalid), 32'h0);
      status = '0;
      tick(2);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < int'(NSRC); b++)
            if ($urandom_range(15) == 0) status[b] = ~status[b];
         wen = 1'b0; ren = 1'b0;
         r = int'($urandom_range(99));
         addr = 2'($urandom_range(3));
         if (r < 25) begin
            ren = 1'b1;
         end else if (r < 37) begin
            wen = 1'b1;
            wdata = $urandom;
            if (addr == 2'd2 && $urandom_range(1) == 1) wdata = 32'(m.act);
            if (addr == 2'd0 && $urandom_range(1) == 1) wdata = 32'(13'($urandom) & 13'($urandom));
         end else if (r < 39) begin
            wen = 1'b1; ren = 1'b1; wdata = $urandom;
         end else if (r < 47) begin
            ren = 1'b1; addr = 2'd2;
         end
         if (c == 2000) begin
            n_rst = 1'b0;
            tick();
            n_rst = 1'b1;
         end
         tick();
      end
      wen = 1'b0; ren = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
